// File: rtl/chimera_router_pkg.sv
// chimera_router_pkg: shared types and helpers for the wide-path region router.
//   rule_t      : one address region {start_addr (inclusive), end_addr (exclusive), port}
//   decode_t    : decode result {hit, port}
//   decode_port : lowest-index-wins region decode with default fallback
//   sel_width   : select width for a given downstream port count (at least 1)
package chimera_router_pkg;

   localparam int unsigned MaxAddrWidth = 64;
   localparam int unsigned MaxRegions   = 32;
   localparam int unsigned MaxSelWidth  = 8;

   typedef logic [MaxAddrWidth-1:0] addr_t;
   typedef logic [MaxSelWidth-1:0]  port_t;

   typedef struct packed {
      addr_t start_addr;
      addr_t end_addr;
      port_t port;
   } rule_t;

   typedef rule_t [MaxRegions-1:0] rule_tbl_t;

   typedef struct packed {
      logic  hit;
      port_t port;
   } decode_t;

   function automatic int unsigned sel_width(input int unsigned num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   // Scan from the highest index down so the lowest matching index is the last
   // write. Unused table entries have start == end and can never hit.
   function automatic decode_t decode_port(input addr_t addr, input rule_tbl_t rules,
                                           input port_t default_port);
      decode_t res;
      res.hit  = 1'b0;
      res.port = default_port;
      for (int i = int'(MaxRegions) - 1; i >= 0; i--) begin
         if (addr >= rules[i].start_addr && addr < rules[i].end_addr) begin
            res.hit  = 1'b1;
            res.port = rules[i].port;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/chimera_route_guard.sv
// chimera_route_guard: per-direction ordering guard. Counts outstanding
// transactions and stalls any request that would change the destination port
// while others are in flight, or that would exceed MaxTxns.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   valid_i/ready_i: upstream valid, downstream ready
//   port_i         : decoded destination port of the presented request
//   done_i         : completion of one outstanding transaction
//   valid_o/ready_o: gated valid to downstream, gated ready to upstream
//   handshake_o    : downstream handshake this cycle
//   stall_o        : request presented but blocked
//   idle_o         : no transactions outstanding
//   underflow_o    : completion seen with nothing outstanding
module chimera_route_guard #(
   parameter int unsigned SelWidth = 2,
   parameter int unsigned MaxTxns  = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic                ready_i,
   input  logic [SelWidth-1:0] port_i,
   input  logic                done_i,
   output logic                valid_o,
   output logic                ready_o,
   output logic                handshake_o,
   output logic                stall_o,
   output logic                idle_o,
   output logic                underflow_o
);

   localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e              state_q;
   logic [CntWidth-1:0] cnt_q;
   logic [CntWidth-1:0] cnt_next;
   logic [SelWidth-1:0] cur_port_q;
   logic                allowed;
   logic                dec;

   always_comb begin
      allowed     = (state_q == StIdle) ||
                    ((port_i == cur_port_q) && (cnt_q < CntWidth'(MaxTxns)));
      valid_o     = !rst_i && allowed && valid_i;
      ready_o     = !rst_i && allowed && ready_i;
      handshake_o = valid_o && ready_i;
      stall_o     = !rst_i && valid_i && !allowed;
      idle_o      = (cnt_q == '0);
      underflow_o = done_i && (cnt_q == '0);
      dec         = done_i && (cnt_q != '0);
      cnt_next    = cnt_q;
      if (handshake_o && !dec) begin
         cnt_next = cnt_q + 1'b1;
      end else if (!handshake_o && dec) begin
         cnt_next = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         cur_port_q <= '0;
      end else begin
         cnt_q   <= cnt_next;
         state_q <= (cnt_next != '0) ? StActive : StIdle;
         if (handshake_o) begin
            cur_port_q <= port_i;
         end
      end
   end

endmodule

// File: rtl/chimera_wide_region_router.sv
// chimera_wide_region_router: address router and ordering guard for a
// cluster's wide AXI master path. Decodes AW/AR addresses into NumRegions
// regions mapped onto NumPorts downstream ports, drives the demux selects, and
// stalls port switches while transactions are outstanding.
//   clk_i, rst_i         : SoC clock, synchronous active-high reset
//   bypass_i             : test bypass request (latched only when fully idle)
//   aw_*/ar_*            : upstream request, gated request to demux, select
//   b_done_i             : write completion; r_last_done_i: read completion
//   bypass_active_o      : latched bypass state
//   err_o                : sticky completion-with-nothing-outstanding flag
// Optional macro CHIMERA_ROUTER_PERF_EN adds stall_cycles_o and miss_count_o.
module chimera_wide_region_router
   import chimera_router_pkg::*;
#(
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned NumRegions = 4,
   parameter int unsigned NumPorts   = 3,
   parameter int unsigned MaxTxns    = 8,
   parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionStart = '0,
   parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionEnd   = '0,
   parameter logic [NumRegions-1:0][sel_width(NumPorts)-1:0] RegionPort = '0,
   parameter int unsigned DefaultPort = 0,
   parameter int unsigned BypassPort  = 0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           bypass_i,
   input  logic                           aw_valid_i,
   input  logic [AddrWidth-1:0]           aw_addr_i,
   output logic                           aw_ready_o,
   output logic                           aw_valid_o,
   input  logic                           aw_ready_i,
   output logic [sel_width(NumPorts)-1:0] aw_select_o,
   input  logic                           b_done_i,
   input  logic                           ar_valid_i,
   input  logic [AddrWidth-1:0]           ar_addr_i,
   output logic                           ar_ready_o,
   output logic                           ar_valid_o,
   input  logic                           ar_ready_i,
   output logic [sel_width(NumPorts)-1:0] ar_select_o,
   input  logic                           r_last_done_i,
   output logic                           bypass_active_o,
   output logic                           err_o
`ifdef CHIMERA_ROUTER_PERF_EN
   ,
   output logic [31:0]                    stall_cycles_o,
   output logic [31:0]                    miss_count_o
`endif
);

   localparam int unsigned SelWidth = sel_width(NumPorts);
   localparam logic [SelWidth-1:0] BypassSel = SelWidth'(BypassPort);

   rule_tbl_t           rules;
   decode_t             aw_dec, ar_dec;
   logic [SelWidth-1:0] aw_port, ar_port;
   logic                bypass_q, err_q;
   logic                aw_hs, ar_hs, aw_stall, ar_stall;
   logic                aw_idle, ar_idle, aw_underflow, ar_underflow;

   // Entries beyond NumRegions stay zero (start == end) and never hit.
   always_comb begin
      rules = '0;
      for (int i = 0; i < int'(NumRegions) && i < int'(MaxRegions); i++) begin
         rules[i].start_addr = addr_t'(RegionStart[i]);
         rules[i].end_addr   = addr_t'(RegionEnd[i]);
         rules[i].port       = port_t'(RegionPort[i]);
      end
   end

   assign aw_dec      = decode_port(addr_t'(aw_addr_i), rules, port_t'(DefaultPort));
   assign ar_dec      = decode_port(addr_t'(ar_addr_i), rules, port_t'(DefaultPort));
   assign aw_port     = bypass_q ? BypassSel : aw_dec.port[SelWidth-1:0];
   assign ar_port     = bypass_q ? BypassSel : ar_dec.port[SelWidth-1:0];
   assign aw_select_o = aw_port;
   assign ar_select_o = ar_port;

   chimera_route_guard #(
      .SelWidth (SelWidth),
      .MaxTxns  (MaxTxns)
   ) u_aw_guard (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (aw_valid_i),
      .ready_i     (aw_ready_i),
      .port_i      (aw_port),
      .done_i      (b_done_i),
      .valid_o     (aw_valid_o),
      .ready_o     (aw_ready_o),
      .handshake_o (aw_hs),
      .stall_o     (aw_stall),
      .idle_o      (aw_idle),
      .underflow_o (aw_underflow)
   );

   chimera_route_guard #(
      .SelWidth (SelWidth),
      .MaxTxns  (MaxTxns)
   ) u_ar_guard (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (ar_valid_i),
      .ready_i     (ar_ready_i),
      .port_i      (ar_port),
      .done_i      (r_last_done_i),
      .valid_o     (ar_valid_o),
      .ready_o     (ar_ready_o),
      .handshake_o (ar_hs),
      .stall_o     (ar_stall),
      .idle_o      (ar_idle),
      .underflow_o (ar_underflow)
   );

   // Bypass only changes when nothing is in flight and nothing is being
   // accepted, so it never reroutes part of a burst.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bypass_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (aw_idle && ar_idle && !aw_hs && !ar_hs) begin
            bypass_q <= bypass_i;
         end
         if (aw_underflow || ar_underflow) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bypass_active_o = bypass_q;
   assign err_o           = err_q;

`ifdef CHIMERA_ROUTER_PERF_EN
   logic [31:0] stall_cycles_q, miss_count_q;
   logic        aw_miss, ar_miss;

   // A miss is a fallback to DefaultPort from the decoder, not a bypass route.
   assign aw_miss = aw_hs && !bypass_q && !aw_dec.hit;
   assign ar_miss = ar_hs && !bypass_q && !ar_dec.hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cycles_q <= '0;
         miss_count_q   <= '0;
      end else begin
         if (aw_stall || ar_stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         miss_count_q <= miss_count_q + 32'(aw_miss) + 32'(ar_miss);
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign miss_count_o   = miss_count_q;
`endif

endmodule

// File: tb/tb_chimera_wide_region_router.sv
// Directed self-checking bench for chimera_wide_region_router.
// Regions: [0x0,0x1000) -> port 1, [0x800,0x2000) -> port 2, default 0, bypass 2.
module tb_chimera_wide_region_router;

   logic        clk = 1'b0;
   logic        rst_i, bypass_i;
   logic        aw_valid_i, aw_ready_i, b_done_i;
   logic        ar_valid_i, ar_ready_i, r_last_done_i;
   logic [47:0] aw_addr_i, ar_addr_i;
   logic        aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o;
   logic [1:0]  aw_select_o, ar_select_o;
   logic        bypass_active_o, err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   chimera_wide_region_router #(
      .AddrWidth   (48),
      .NumRegions  (4),
      .NumPorts    (3),
      .MaxTxns     (8),
      .RegionStart ({48'h0, 48'h0, 48'h800, 48'h0}),
      .RegionEnd   ({48'h0, 48'h0, 48'h2000, 48'h1000}),
      .RegionPort  ({2'd0, 2'd0, 2'd2, 2'd1}),
      .DefaultPort (0),
      .BypassPort  (2)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .bypass_i        (bypass_i),
      .aw_valid_i      (aw_valid_i),
      .aw_addr_i       (aw_addr_i),
      .aw_ready_o      (aw_ready_o),
      .aw_valid_o      (aw_valid_o),
      .aw_ready_i      (aw_ready_i),
      .aw_select_o     (aw_select_o),
      .b_done_i        (b_done_i),
      .ar_valid_i      (ar_valid_i),
      .ar_addr_i       (ar_addr_i),
      .ar_ready_o      (ar_ready_o),
      .ar_valid_o      (ar_valid_o),
      .ar_ready_i      (ar_ready_i),
      .ar_select_o     (ar_select_o),
      .r_last_done_i   (r_last_done_i),
      .bypass_active_o (bypass_active_o),
      .err_o           (err_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; bypass_i = 1'b0; b_done_i = 1'b0; r_last_done_i = 1'b0;
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_addr_i = 48'h100;
      ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_addr_i = 48'h100;
      step();
      #1;
      total++; if (aw_valid_o !== 1'b0) begin bad++; $display("FAIL reset_aw_valid: got %b want 0", aw_valid_o); end
      total++; if (aw_ready_o !== 1'b0) begin bad++; $display("FAIL reset_aw_ready: got %b want 0", aw_ready_o); end
      total++; if (ar_valid_o !== 1'b0) begin bad++; $display("FAIL reset_ar_valid: got %b want 0", ar_valid_o); end
      total++; if (ar_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ar_ready: got %b want 0", ar_ready_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
      total++; if (bypass_active_o !== 1'b0) begin bad++; $display("FAIL reset_bypass: got %b want 0", bypass_active_o); end
      aw_valid_i = 1'b0; aw_ready_i = 1'b0; ar_valid_i = 1'b0; ar_ready_i = 1'b0;
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_decode();
      logic [47:0] addrs [7];
      logic [1:0]  exp   [7];
      addrs = '{48'h900, 48'h3000, 48'hFFF, 48'h1000, 48'h1FFF, 48'h2000, 48'h0};
      exp   = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
      aw_valid_i = 1'b1; aw_ready_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         aw_addr_i = addrs[i];
         #1;
         total++;
         if (aw_select_o !== exp[i]) begin
            bad++; $display("FAIL decode_aw addr=%h: got %0d want %0d", addrs[i], aw_select_o, exp[i]);
         end
      end
      aw_addr_i = 48'h900;
      #1;
      total++; if (aw_valid_o !== 1'b1) begin bad++; $display("FAIL decode_passthru_valid: got %b want 1", aw_valid_o); end
      total++; if (aw_ready_o !== 1'b0) begin bad++; $display("FAIL decode_passthru_ready: got %b want 0", aw_ready_o); end
      // Select is driven even with valid low.
      ar_valid_i = 1'b0; ar_addr_i = 48'h1800;
      #1;
      total++; if (ar_select_o !== 2'd2) begin bad++; $display("FAIL decode_ar_idle_sel: got %0d want 2", ar_select_o); end
      total++; if (ar_valid_o !== 1'b0) begin bad++; $display("FAIL decode_ar_valid: got %b want 0", ar_valid_o); end
      aw_valid_i = 1'b0;
      step();
   endtask

   task automatic test_port_switch();
      ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_addr_i = 48'h100;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (ar_valid_o !== 1'b1) begin bad++; $display("FAIL switch_issue%0d: got %b want 1", i, ar_valid_o); end
         step();
      end
      ar_addr_i = 48'h1800;
      for (int i = 0; i < 3; i++) begin
         r_last_done_i = 1'b1;
         #1;
         total++; if (ar_valid_o !== 1'b0) begin bad++; $display("FAIL switch_stall_valid%0d: got %b want 0", i, ar_valid_o); end
         total++; if (ar_ready_o !== 1'b0) begin bad++; $display("FAIL switch_stall_ready%0d: got %b want 0", i, ar_ready_o); end
         step();
      end
      r_last_done_i = 1'b0;
      #1;
      total++; if (ar_valid_o !== 1'b1) begin bad++; $display("FAIL switch_release_valid: got %b want 1", ar_valid_o); end
      total++; if (ar_ready_o !== 1'b1) begin bad++; $display("FAIL switch_release_ready: got %b want 1", ar_ready_o); end
      total++; if (ar_select_o !== 2'd2) begin bad++; $display("FAIL switch_release_sel: got %0d want 2", ar_select_o); end
      step();
      ar_valid_i = 1'b0; ar_ready_i = 1'b0; r_last_done_i = 1'b1;
      step();
      r_last_done_i = 1'b0;
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL switch_err: got %b want 0", err_o); end
   endtask

   task automatic test_full();
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_addr_i = 48'h100;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++; if (aw_valid_o !== 1'b1) begin bad++; $display("FAIL full_issue%0d: got %b want 1", i, aw_valid_o); end
         step();
      end
      #1;
      total++; if (aw_valid_o !== 1'b0) begin bad++; $display("FAIL full_stall_valid: got %b want 0", aw_valid_o); end
      total++; if (aw_ready_o !== 1'b0) begin bad++; $display("FAIL full_stall_ready: got %b want 0", aw_ready_o); end
      step();
      b_done_i = 1'b1;
      #1;
      total++; if (aw_valid_o !== 1'b0) begin bad++; $display("FAIL full_stall_done_cycle: got %b want 0", aw_valid_o); end
      step();
      b_done_i = 1'b0;
      #1;
      total++; if (aw_valid_o !== 1'b1) begin bad++; $display("FAIL full_ninth_valid: got %b want 1", aw_valid_o); end
      total++; if (aw_ready_o !== 1'b1) begin bad++; $display("FAIL full_ninth_ready: got %b want 1", aw_ready_o); end
      step();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0; b_done_i = 1'b1;
      repeat (8) step();
      b_done_i = 1'b0;
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL full_drain_err: got %b want 0", err_o); end
   endtask

   task automatic test_simultaneous();
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_addr_i = 48'h100;
      repeat (3) step();
      b_done_i = 1'b1;
      #1;
      total++; if (aw_valid_o !== 1'b1) begin bad++; $display("FAIL simul_hs_valid: got %b want 1", aw_valid_o); end
      step();
      // Count must still be 3: a port-2 request stalls across exactly 3 completions.
      aw_addr_i = 48'h1800;
      for (int i = 0; i < 3; i++) begin
         b_done_i = 1'b1;
         #1;
         total++; if (aw_valid_o !== 1'b0) begin bad++; $display("FAIL simul_stall%0d: got %b want 0", i, aw_valid_o); end
         step();
      end
      b_done_i = 1'b0;
      #1;
      total++; if (aw_valid_o !== 1'b1) begin bad++; $display("FAIL simul_release: got %b want 1", aw_valid_o); end
      step();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0; b_done_i = 1'b1;
      step();
      b_done_i = 1'b0;
   endtask

   task automatic test_bypass();
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_addr_i = 48'h100;
      repeat (2) step();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0; bypass_i = 1'b1;
      step();
      total++; if (bypass_active_o !== 1'b0) begin bad++; $display("FAIL bypass_hold2: got %b want 0", bypass_active_o); end
      b_done_i = 1'b1;
      step();
      total++; if (bypass_active_o !== 1'b0) begin bad++; $display("FAIL bypass_hold1: got %b want 0", bypass_active_o); end
      step();
      b_done_i = 1'b0;
      total++; if (bypass_active_o !== 1'b0) begin bad++; $display("FAIL bypass_hold0: got %b want 0", bypass_active_o); end
      step();
      total++; if (bypass_active_o !== 1'b1) begin bad++; $display("FAIL bypass_set: got %b want 1", bypass_active_o); end
      aw_valid_i = 1'b1; aw_addr_i = 48'h900; ar_addr_i = 48'h3000;
      #1;
      total++; if (aw_select_o !== 2'd2) begin bad++; $display("FAIL bypass_aw_sel: got %0d want 2", aw_select_o); end
      total++; if (ar_select_o !== 2'd2) begin bad++; $display("FAIL bypass_ar_sel: got %0d want 2", ar_select_o); end
      total++; if (aw_valid_o !== 1'b1) begin bad++; $display("FAIL bypass_aw_valid: got %b want 1", aw_valid_o); end
      aw_valid_i = 1'b0; bypass_i = 1'b0;
      step();
      total++; if (bypass_active_o !== 1'b0) begin bad++; $display("FAIL bypass_clear: got %b want 0", bypass_active_o); end
      total++; if (aw_select_o !== 2'd1) begin bad++; $display("FAIL bypass_clear_sel: got %0d want 1", aw_select_o); end
   endtask

   task automatic test_error_reset();
      b_done_i = 1'b1;
      step();
      b_done_i = 1'b0;
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_o); end
      step();
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_held: got %b want 1", err_o); end
      rst_i = 1'b1;
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; ar_valid_i = 1'b1; ar_ready_i = 1'b1;
      aw_addr_i = 48'h100; ar_addr_i = 48'h100;
      #1;
      total++; if (aw_valid_o !== 1'b0) begin bad++; $display("FAIL rst_aw_valid: got %b want 0", aw_valid_o); end
      total++; if (ar_valid_o !== 1'b0) begin bad++; $display("FAIL rst_ar_valid: got %b want 0", ar_valid_o); end
      step();
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err_clear: got %b want 0", err_o); end
      total++; if (aw_valid_o !== 1'b0) begin bad++; $display("FAIL rst_aw_valid_hold: got %b want 0", aw_valid_o); end
      aw_valid_i = 1'b0; aw_ready_i = 1'b0; ar_valid_i = 1'b0; ar_ready_i = 1'b0;
      rst_i = 1'b0;
      step();
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err_after: got %b want 0", err_o); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_port_switch();
      test_full();
      test_simultaneous();
      test_bypass();
      test_error_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
